// File: rtl/ew_source_sequencer_pkg.sv
// Shared definitions for the event-window source sequencer:
// spill-tag width, default window timeout and the FSM state encoding.
package ew_source_sequencer_pkg;

    localparam int SPILL_TAG_BITS = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } ew_state_e;

endpackage

// File: rtl/ew_source_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones, clr has priority over inc.
// Ports: clk, rst (sync, active-high), inc, clr, count[WIDTH-1:0].
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ew_source_sequencer.sv
// EW source-mux sequencer: latches pattern_en between windows, delays the
// start pulse by one cycle, tracks each window to done/timeout and keeps
// status counters. Optional spill-tag continuity check: EW_TAG_CHECK_EN.
// Ports: serdesclk, serdes_rst (sync, active-high); pattern_en_req,
// axi_start_in, ew_done, ew_ovfl, ew_tag, cnt_clr in; pattern_en,
// axi_start_on_serdesclk, busy, window_cnt, ovfl_cnt, drop_cnt,
// timeout_cnt and (with EW_TAG_CHECK_EN) tag_err_cnt out.
module ew_source_sequencer
    import ew_source_sequencer_pkg::*;
#(
    parameter int TIMEOUT_BITS = 20,
    parameter logic [TIMEOUT_BITS-1:0] TIMEOUT_CYCLES =
        TIMEOUT_BITS'(DEFAULT_TIMEOUT_CYCLES)
) (
    input  logic                      serdesclk,
    input  logic                      serdes_rst,
    input  logic                      pattern_en_req,
    input  logic                      axi_start_in,
    input  logic                      ew_done,
    input  logic                      ew_ovfl,
    input  logic [SPILL_TAG_BITS-1:0] ew_tag,
    input  logic                      cnt_clr,
    output logic                      pattern_en,
    output logic                      axi_start_on_serdesclk,
    output logic                      busy,
    output logic [31:0]               window_cnt,
    output logic [15:0]               ovfl_cnt,
    output logic [15:0]               drop_cnt,
    output logic [15:0]               timeout_cnt
`ifdef EW_TAG_CHECK_EN
    ,
    output logic [7:0]                tag_err_cnt
`endif
);

    ew_state_e                 state;
    ew_state_e                 state_next;
    logic                      done_prev;
    logic                      done_pend;
    logic                      done_rise;
    logic                      done_evt;
    logic [TIMEOUT_BITS-1:0]   tcnt;
    logic                      tmo_hit;
    logic                      load_pat;
    logic                      finish;
    logic                      expire;
    logic                      drop;

    assign done_rise = ew_done && !done_prev;
    // A rise seen during LAUNCH is held one cycle and consumed in BUSY.
    assign done_evt  = done_rise || done_pend;
    assign tmo_hit   = (tcnt == TIMEOUT_CYCLES - TIMEOUT_BITS'(1));
    assign drop      = axi_start_in && (state != ST_IDLE);

    assign axi_start_on_serdesclk = (state == ST_LAUNCH);
    assign busy                   = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        load_pat   = 1'b0;
        finish     = 1'b0;
        expire     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // A start freezes the select at its current value.
                load_pat = !axi_start_in;
                if (axi_start_in) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (done_evt) begin
                    finish     = 1'b1;
                    load_pat   = 1'b1;
                    state_next = ST_IDLE;
                end else if (tmo_hit) begin
                    expire     = 1'b1;
                    load_pat   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge serdesclk) begin
        if (serdes_rst) begin
            state      <= ST_IDLE;
            pattern_en <= 1'b0;
            done_prev  <= 1'b0;
            done_pend  <= 1'b0;
            tcnt       <= '0;
            window_cnt <= '0;
        end else begin
            state     <= state_next;
            done_prev <= ew_done;
            done_pend <= (state == ST_LAUNCH) && done_rise;
            if (load_pat) begin
                // Loading on BUSY exit makes a deferred request visible
                // in the first IDLE cycle.
                pattern_en <= pattern_en_req;
            end
            if (state == ST_LAUNCH) begin
                tcnt <= '0;
            end else if (state == ST_BUSY) begin
                tcnt <= tcnt + TIMEOUT_BITS'(1);
            end
            if (cnt_clr) begin
                window_cnt <= '0;
            end else if (finish) begin
                window_cnt <= window_cnt + 32'd1;
            end
        end
    end

    sat_counter #(.WIDTH(16)) u_ovfl_cnt (
        .clk   (serdesclk),
        .rst   (serdes_rst),
        .inc   (finish && ew_ovfl),
        .clr   (cnt_clr),
        .count (ovfl_cnt)
    );

    sat_counter #(.WIDTH(16)) u_drop_cnt (
        .clk   (serdesclk),
        .rst   (serdes_rst),
        .inc   (drop),
        .clr   (cnt_clr),
        .count (drop_cnt)
    );

    sat_counter #(.WIDTH(16)) u_timeout_cnt (
        .clk   (serdesclk),
        .rst   (serdes_rst),
        .inc   (expire),
        .clr   (cnt_clr),
        .count (timeout_cnt)
    );

`ifdef EW_TAG_CHECK_EN
    logic [SPILL_TAG_BITS-1:0] seed;
    logic                      seed_valid;
    logic [SPILL_TAG_BITS-1:0] tag_exp;
    logic                      tag_err;

    // Wraps naturally, so all-ones followed by zero is continuous.
    assign tag_exp = seed + SPILL_TAG_BITS'(1);
    assign tag_err = finish && seed_valid && (ew_tag != tag_exp);

    always_ff @(posedge serdesclk) begin
        if (serdes_rst) begin
            seed       <= '0;
            seed_valid <= 1'b0;
        end else if (cnt_clr) begin
            seed_valid <= 1'b0;
        end else if (finish) begin
            // Matching or not, the next check is relative to this tag.
            seed       <= ew_tag;
            seed_valid <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(8)) u_tag_err_cnt (
        .clk   (serdesclk),
        .rst   (serdes_rst),
        .inc   (tag_err),
        .clr   (cnt_clr),
        .count (tag_err_cnt)
    );
`else
    logic unused_tag;
    assign unused_tag = ^ew_tag;
`endif

endmodule

// File: tb/tb_ew_source_sequencer.sv
// Self-checking bench for ew_source_sequencer: directed scenarios then a
// randomized run, all checked against a window-level reference model.
module tb_ew_source_sequencer;
    import ew_source_sequencer_pkg::*;

    localparam int TMO  = 16;
    localparam int TAGM = 1 << SPILL_TAG_BITS;

    logic                      serdesclk = 1'b0;
    logic                      serdes_rst;
    logic                      pattern_en_req;
    logic                      axi_start_in;
    logic                      ew_done;
    logic                      ew_ovfl;
    logic [SPILL_TAG_BITS-1:0] ew_tag;
    logic                      cnt_clr;
    logic                      pattern_en;
    logic                      axi_start_on_serdesclk;
    logic                      busy;
    logic [31:0]               window_cnt;
    logic [15:0]               ovfl_cnt;
    logic [15:0]               drop_cnt;
    logic [15:0]               timeout_cnt;
`ifdef EW_TAG_CHECK_EN
    logic [7:0]                tag_err_cnt;
`endif

    ew_source_sequencer #(
        .TIMEOUT_BITS   (20),
        .TIMEOUT_CYCLES (20'd16)
    ) dut (
        .serdesclk              (serdesclk),
        .serdes_rst             (serdes_rst),
        .pattern_en_req         (pattern_en_req),
        .axi_start_in           (axi_start_in),
        .ew_done                (ew_done),
        .ew_ovfl                (ew_ovfl),
        .ew_tag                 (ew_tag),
        .cnt_clr                (cnt_clr),
        .pattern_en             (pattern_en),
        .axi_start_on_serdesclk (axi_start_on_serdesclk),
        .busy                   (busy),
        .window_cnt             (window_cnt),
        .ovfl_cnt               (ovfl_cnt),
        .drop_cnt               (drop_cnt),
`ifdef EW_TAG_CHECK_EN
        .timeout_cnt            (timeout_cnt),
        .tag_err_cnt            (tag_err_cnt)
`else
        .timeout_cnt            (timeout_cnt)
`endif
    );

    always #5 serdesclk = ~serdesclk;

    int checks = 0;
    int errors = 0;
    bit quiet  = 1'b0;

    bit g_req = 1'b0;
    bit g_dn  = 1'b0;
    bit g_ov  = 1'b0;
    int g_tag = 0;

    // Reference model: a window is open from an accepted start until a
    // done edge or TMO busy cycles; m_age counts cycles since acceptance.
    bit          m_open, m_pend, m_prev, m_pat, m_seed_ok;
    int          m_age, m_seed;
    int          m_ovfl, m_drop, m_tmo, m_terr;
    logic [31:0] m_win;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit st, input bit dn,
                         input bit ov, input bit req, input bit clr,
                         input int tag);
        bit rise, fin, tmo, drp;
        fin = 0;
        tmo = 0;
        drp = 0;
        if (rst) begin
            m_open = 0; m_pend = 0; m_prev = 0; m_pat = 0;
            m_age = 0; m_seed = 0; m_seed_ok = 0;
            m_win = 0; m_ovfl = 0; m_drop = 0; m_tmo = 0; m_terr = 0;
        end else begin
            rise   = dn && !m_prev;
            m_prev = dn;
            if (!m_open) begin
                if (st) begin
                    m_open = 1;
                    m_age  = 1;
                    m_pend = 0;
                end else begin
                    m_pat = req;
                end
            end else begin
                drp = st;
                if (m_age == 1) begin
                    m_pend = rise;
                    m_age  = 2;
                end else begin
                    if (rise || m_pend) fin = 1;
                    else if (m_age - 1 == TMO) tmo = 1;
                    m_pend = 0;
                    if (fin || tmo) begin
                        m_open = 0;
                        m_pat  = req;
                    end else begin
                        m_age++;
                    end
                end
            end
            if (clr) begin
                m_win = 0; m_ovfl = 0; m_drop = 0; m_tmo = 0; m_terr = 0;
                m_seed_ok = 0;
            end else begin
                if (fin) m_win = m_win + 1;
                if (fin && ov && m_ovfl < 65535) m_ovfl++;
                if (drp && m_drop < 65535) m_drop++;
                if (tmo && m_tmo < 65535) m_tmo++;
                if (fin) begin
                    if (m_seed_ok && tag != (m_seed + 1) % TAGM && m_terr < 255)
                        m_terr++;
                    m_seed    = tag;
                    m_seed_ok = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("pattern_en", pattern_en, m_pat);
        chk("start_out", axi_start_on_serdesclk, m_open && m_age == 1);
        chk("busy", busy, m_open);
        chk("window_cnt", window_cnt, m_win);
        chk("ovfl_cnt", ovfl_cnt, m_ovfl);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("timeout_cnt", timeout_cnt, m_tmo);
`ifdef EW_TAG_CHECK_EN
        chk("tag_err_cnt", tag_err_cnt, m_terr);
`endif
    endtask

    task automatic tick(input bit st = 0, input bit clr = 0,
                        input bit rst = 0);
        serdes_rst     = rst;
        axi_start_in   = st;
        cnt_clr        = clr;
        pattern_en_req = g_req;
        ew_done        = g_dn;
        ew_ovfl        = g_ov;
        ew_tag         = SPILL_TAG_BITS'(g_tag);
        @(posedge serdesclk);
        model(rst, st, g_dn, g_ov, g_req, clr, g_tag);
        #1;
        if (!quiet) compare_all();
    endtask

    // Minimum-length window: start, LAUNCH, done edge, back in IDLE.
    task automatic win(input int tag);
        g_tag = tag;
        g_dn  = 0;
        tick(.st(1));
        tick();
        g_dn = 1;
        tick();
    endtask

    initial begin
        int k;
        tick(.rst(1));
        tick(.rst(1));
        chk("rst_busy", busy, 0);
        chk("rst_pat", pattern_en, 0);
        chk("rst_start", axi_start_on_serdesclk, 0);
        chk("rst_win", window_cnt, 0);
        chk("rst_drop", drop_cnt, 0);

        g_req = 1;
        tick();
        tick();
        tick(.st(1));
        chk("t1_pat", pattern_en, 1);
        chk("t1_start", axi_start_on_serdesclk, 1);
        tick();
        tick();
        g_req = 0;
        tick();
        chk("t1_pat_hold", pattern_en, 1);
        tick();
        chk("t1_pat_hold2", pattern_en, 1);
        g_dn = 1;
        tick();
        chk("t1_win", window_cnt, 1);
        chk("t1_busy", busy, 0);
        chk("t1_pat_idle", pattern_en, 0);
        g_dn = 0;
        tick();

        tick(.clr(1));
        chk("clr_win", window_cnt, 0);
        tick(.st(1));
        tick();
        tick(.st(1));
        tick(.st(1));
        g_dn = 1;
        tick(.st(1));
        chk("drop3", drop_cnt, 3);
        chk("drop_win", window_cnt, 1);
        g_dn = 0;
        tick();

        tick(.clr(1));
        tick(.st(1));
        k = 0;
        while (k < 40 && busy) begin
            tick();
            k++;
        end
        chk("tmo_len", k, TMO + 1);
        chk("tmo_cnt", timeout_cnt, 1);
        tick(.clr(1));
        tick(.st(1));
        repeat (TMO) tick();
        g_dn = 1;
        tick();
        chk("tmo_done_tmo", timeout_cnt, 0);
        chk("tmo_done_win", window_cnt, 1);
        g_dn = 0;
        tick();
        tick(.st(1));
        g_dn = 1;
        tick();
        tick();
        chk("launch_done_busy", busy, 0);
        chk("launch_done_win", window_cnt, 2);

        win(1);
        chk("minwin_idle", busy, 0);
        win(2);
        chk("minwin_b2b", window_cnt, 4);

        g_req = 1;
        g_dn  = 0;
        tick();
        tick(.st(1));
        tick();
        tick();
        tick(.rst(1));
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pat", pattern_en, 0);
        chk("mid_rst_win", window_cnt, 0);
        chk("mid_rst_tmo", timeout_cnt, 0);

`ifdef EW_TAG_CHECK_EN
        tick(.clr(1));
        win(TAGM - 2);
        win(TAGM - 1);
        win(0);
        win(2);
        win(3);
        chk("tag_err1", tag_err_cnt, 1);
        tick(.clr(1));
        win(9);
        chk("tag_seed", tag_err_cnt, 0);
`endif

        g_dn  = 0;
        quiet = 1;
        repeat (70000) tick(.st(1));
        quiet = 0;
        tick();
        chk("drop_sat", drop_cnt, 16'hFFFF);

        tick(.rst(1));
        for (int i = 0; i < 3000; i++) begin
            bit st, clr, rst;
            g_req = 1'($urandom_range(0, 1));
            g_dn  = ($urandom_range(0, 4) == 0);
            g_ov  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                g_tag = (g_tag + 1) % TAGM;
            else
                g_tag = int'($urandom_range(0, TAGM - 1));
            st  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick(.st(st), .clr(clr), .rst(rst));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ew_source_sequencer.md
# ew_source_sequencer

Control block for the event-window (EW) source mux, running in the SERDES clock domain. It owns `pattern_en`: a mode request from the register file is latched only between event windows, so the DIGI/PATTERN selection never changes while a window is open. It delays each `axi_start_on_serdesclk` by one cycle so the mux selection is settled before the start pulse is steered. It also tracks each window to completion or timeout and maintains status counters, including an optional spill-tag continuity check.

## Interface
Parameters:
- `TIMEOUT_BITS`, 20: width of the window-timeout counter.
- `TIMEOUT_CYCLES`, 20'd1000000: serdesclk cycles in BUSY before the window is abandoned; must be ≥ 1.

Ports (widths from `tracker_params.vh`):
- `serdesclk`  in  1  clock; one clock domain only.
- `serdes_rst`  in  1  reset; synchronous, active-high.
- `pattern_en_req`  in  1  requested mode from the register file (1 = PATTERN source).
- `axi_start_in`  in  1  start-of-window pulse, 1 cycle.
- `ew_done`  in  1  muxed window-done from the source switch; may be a pulse or a level.
- `ew_ovfl`  in  1  muxed overflow flag; sampled when a window completes.
- `ew_tag`  in  `SPILL_TAG_BITS`  muxed spill tag; sampled when a window completes.
- `cnt_clr`  in  1  pulse; clears all counters and the tag seed.
- `pattern_en`  out  1  registered mux select.
- `axi_start_on_serdesclk`  out  1  delayed start pulse, driven into the switch.
- `busy`  out  1  high in LAUNCH or BUSY.
- `window_cnt`  out  32  completed windows; wraps.
- `ovfl_cnt`  out  16  completed windows that had `ew_ovfl`=1; saturating.
- `drop_cnt`  out  16  starts rejected while busy; saturating.
- `timeout_cnt`  out  16  windows abandoned on timeout; saturating.
- `tag_err_cnt`  out  8  tag discontinuities; saturating. Present only with `EW_TAG_CHECK_EN`.

## Operation
- State machine: IDLE, LAUNCH, BUSY.
- **IDLE**
  - `pattern_en <= pattern_en_req` on every cycle.
  - On `axi_start_in`: freeze `pattern_en` at its current value, go to LAUNCH.
- **LAUNCH** (exactly 1 cycle)
  - `axi_start_on_serdesclk`=1; clear the timeout counter; go to BUSY.
- **BUSY**
  - Timeout counter increments every cycle.
  - On a done event: `window_cnt`++; `ovfl_cnt`++ if `ew_ovfl`; run the tag check; go to IDLE.
  - Else if the counter reaches `TIMEOUT_CYCLES`-1: `timeout_cnt`++; go to IDLE.
- **Done event** = rising edge of `ew_done`, using a registered previous value. A rising edge during LAUNCH is latched and consumed on the first BUSY cycle.
- `pattern_en` is held constant from the start of LAUNCH until the return to IDLE. A change of `pattern_en_req` during a window is deferred, not lost.
- `axi_start_in` in LAUNCH or BUSY: `drop_cnt`++; no queuing.
- Simultaneous events:
  - Done and timeout on the same cycle: done wins; `timeout_cnt` unchanged.
  - Done and `axi_start_in` on the same cycle: the window completes and the start is dropped.
- `cnt_clr` takes priority over an increment on the same cycle. It does not change the state or `pattern_en`.
- Saturating counters hold at all-ones. `window_cnt` wraps to 0.

## Timing
- Reset values: state IDLE, `pattern_en`=0, all counters 0, `axi_start_on_serdesclk`=0, `busy`=0, tag seed invalid.
- Reset in the middle of a window: next cycle IDLE, no counter updates, no pending start.
- Latency from `axi_start_in` to `axi_start_on_serdesclk`: 1 cycle.
- `pattern_en` is valid in the cycle before the start pulse and in the cycle of the pulse.
- Minimum window: start at T, LAUNCH at T+1, done edge at T+2, IDLE at T+3, next start accepted at T+3.
- Counter outputs are registered; each update is visible 1 cycle after its event.

## Configuration
- `EW_TAG_CHECK_EN` defined:
  - On each completed window with a valid seed, compare `ew_tag` against expected = previous tag + 1, modulo 2^`SPILL_TAG_BITS` (so the all-ones tag followed by 0 is legal).
  - On a mismatch, `tag_err_cnt`++ and resync the seed to `ew_tag`.
  - The first completion after reset or `cnt_clr` only seeds; no check.
- `EW_TAG_CHECK_EN` undefined: no seed register, no comparator; the `tag_err_cnt` port does not exist.

## Structure
- `SPILL_TAG_BITS` and the state encodings belong in the shared `tracker_params.vh`.
- Default `TIMEOUT_CYCLES` belongs in the shared `tracker_params.vh`.
- One sub-module: `sat_counter` (parameter `WIDTH`; inputs `inc`, `clr`; saturates at all-ones). It is instanced for `ovfl_cnt`, `drop_cnt`, `timeout_cnt` and `tag_err_cnt`.

## Test plan
- `pattern_en_req`=1 in IDLE, start at T → `pattern_en`=1 at T+1, start pulse out at T+1, done at T+5 → `window_cnt`=1, `busy`=0 at T+6.
- Drop `pattern_en_req` to 0 during BUSY → `pattern_en` stays 1 until done; it is 0 in the first IDLE cycle after done.
- Three starts during BUSY, one of them coincident with done → `drop_cnt`=3, `window_cnt`=1.
- `TIMEOUT_CYCLES`=16, no done → `timeout_cnt`=1, FSM returns to IDLE at 16 BUSY cycles; done coincident with expiry → `timeout_cnt`=0, `window_cnt`=1.
- `EW_TAG_CHECK_EN` with `SPILL_TAG_BITS`=4:
  - Tags 14, 15, 0, 2, 3 → `tag_err_cnt`=1.
  - `cnt_clr`, then tag 9 → seeds only, `tag_err_cnt`=0.
- Assert reset during BUSY → next cycle IDLE, `pattern_en`=0, all counters 0; a 70000-drop run → `drop_cnt`=16'hFFFF.
